// File: rtl/des_key_if.sv
// Round-key request/delivery bundle between the DES round datapath and the key scheduler.
// The master side is the datapath; the slave side is des_key_sched.
interface des_key_if;
   logic        start;
   logic        decrypt;
   logic [63:0] key_in;
   logic        advance;
   logic [47:0] r_key;
   logic        key_valid;
   logic [3:0]  round;
   logic        done;

   modport master (
      output start, decrypt, key_in, advance,
      input  r_key, key_valid, round, done
   );

   modport slave (
      input  start, decrypt, key_in, advance,
      output r_key, key_valid, round, done
   );
endinterface

// File: rtl/des_key_sched.sv
// Iterative DES key schedule: PC-1 on load, one PC-2 round key per advance, 16 rounds,
// in forward (encrypt) or reverse (decrypt) order.
module des_key_sched (
   input logic      clk,
   input logic      rst_n,
   des_key_if.slave bus
);

   typedef enum logic {StIdle, StRun} state_e;

   localparam int unsigned Pc1Tab [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned Pc2Tab [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // DES bit n of the key lives at key[64-n]; bit n of C||D lives at cd[56-n].
   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] o;
      o = '0;
      for (int i = 0; i < 56; i++) o[55-i] = k[64-Pc1Tab[i]];
      return o;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] o;
      o = '0;
      for (int i = 0; i < 48; i++) o[47-i] = cd[56-Pc2Tab[i]];
      return o;
   endfunction

   // Keys 1, 2, 9 and 16 rotate by one position; all others by two.
   function automatic logic shift_two(input int n);
      return !(n == 1 || n == 2 || n == 9 || n == 16);
   endfunction

   function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
      return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
      return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   state_e      state_q, state_d;
   logic [27:0] c_q, c_d, d_q, d_d;
   logic [3:0]  round_q, round_d;
   logic        dir_q, dir_d;
   logic        done_q, done_d;
   logic [55:0] cd_load;
   logic        two;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         c_q     <= '0;
         d_q     <= '0;
         round_q <= '0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         round_q <= round_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      round_d = round_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      cd_load = pc1(bus.key_in);
      two     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StRun;
               round_d = '0;
               dir_d   = bus.decrypt;
               // Decrypt starts at K16, whose C/D equal the unrotated PC-1 halves.
               if (bus.decrypt) begin
                  c_d = cd_load[55:28];
                  d_d = cd_load[27:0];
               end else begin
                  c_d = rotl(cd_load[55:28], 1'b0);
                  d_d = rotl(cd_load[27:0], 1'b0);
               end
            end
         end
         StRun: begin
            if (bus.advance) begin
               if (round_q == 4'd15) begin
                  state_d = StIdle;
                  round_d = '0;
                  done_d  = 1'b1;
               end else begin
                  round_d = round_q + 4'd1;
                  if (dir_q) begin
                     two = shift_two(16 - int'(round_q));
                     c_d = rotr(c_q, two);
                     d_d = rotr(d_q, two);
                  end else begin
                     two = shift_two(int'(round_q) + 2);
                     c_d = rotl(c_q, two);
                     d_d = rotl(d_q, two);
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.r_key     = pc2({c_q, d_q});
   assign bus.key_valid = (state_q == StRun);
   assign bus.round     = round_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Randomized scoreboard bench for des_key_sched against a direct DES key-schedule model.
module tb_des_key_sched;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   des_key_if bus ();

   des_key_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   localparam int Pc1Tab [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int Pc2Tab [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int ShiftTab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   localparam logic [63:0] KnownKey = 64'h1334_5779_9BBC_DFF1;
   localparam logic [63:0] ParKey   = 64'h1234_5678_9ABC_DEF0;

   typedef struct packed {
      logic [47:0] key;
      logic [3:0]  round;
   } exp_t;

   exp_t        exp_q [$];
   int          checks   = 0;
   int          errors   = 0;
   int          done_exp = 0;
   logic [47:0] ks [16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Ki = PC-2 of the PC-1 halves each rotated left by the cumulative shift up to round i.
   function automatic void model(input logic [63:0] key);
      bit cd0 [1:56];
      bit cdi [1:56];
      int s;
      s = 0;
      for (int n = 1; n <= 56; n++) cd0[n] = key[64-Pc1Tab[n-1]];
      for (int i = 0; i < 16; i++) begin
         s += ShiftTab[i];
         for (int j = 1; j <= 28; j++) begin
            cdi[j]      = cd0[((j - 1 + s) % 28) + 1];
            cdi[j + 28] = cd0[((j - 1 + s) % 28) + 29];
         end
         for (int m = 1; m <= 48; m++) ks[i][48-m] = cdi[Pc2Tab[m-1]];
      end
   endfunction

   // Monitor: compares whatever key is presented; retires it when the consumer advances.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_key: got r_key %h round %0d, expected none",
                        bus.r_key, bus.round);
            end else begin
               check("r_key", 64'(bus.r_key), 64'(exp_q[0].key));
               check("round", 64'(bus.round), 64'(exp_q[0].round));
               if (bus.advance === 1'b1) void'(exp_q.pop_front());
            end
         end
         if (bus.done === 1'b1) begin
            check("done_expected", 64'(done_exp > 0), 64'(1));
            if (done_exp > 0) done_exp--;
         end
      end
   end

   task automatic check_known(input int k, input bit dec);
      if (!dec && k == 0)  check("enc_k1",  64'(bus.r_key), 64'(48'h1B02EFFC7072));
      if (!dec && k == 1)  check("enc_k2",  64'(bus.r_key), 64'(48'h79AED9DBC9E5));
      if (!dec && k == 15) check("enc_k16", 64'(bus.r_key), 64'(48'hCB3D8B0E17F5));
      if (dec && k == 0)   check("dec_first", 64'(bus.r_key), 64'(48'hCB3D8B0E17F5));
      if (dec && k == 15)  check("dec_last",  64'(bus.r_key), 64'(48'h1B02EFFC7072));
   endtask

   task automatic issue_start(input logic [63:0] key, input logic [63:0] mkey, input bit dec,
                              input bit combo);
      exp_t e;
      model(mkey);
      bus.start   = 1'b1;
      bus.decrypt = dec;
      bus.key_in  = key;
      bus.advance = combo;
      for (int r = 0; r < 16; r++) begin
         e.key   = dec ? ks[15-r] : ks[r];
         e.round = 4'(r);
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      bus.start   = 1'b0;
      bus.advance = 1'b0;
      check("key_valid_after_start", 64'(bus.key_valid), 64'(1));
      check("round_after_start", 64'(bus.round), 64'(0));
   endtask

   task automatic run(input logic [63:0] key, input logic [63:0] mkey, input bit dec,
                      input bit known, input bit combo, input int stall_at, input bit poke,
                      input bit gaps);
      int          g;
      logic [47:0] held;
      issue_start(key, mkey, dec, combo);
      for (int k = 0; k < 16; k++) begin
         if (known) check_known(k, dec);
         if (k == stall_at) begin
            held = bus.r_key;
            repeat (5) begin
               @(posedge clk); #1;
               check("stall_round", 64'(bus.round), 64'(k));
               check("stall_key", 64'(bus.r_key), 64'(held));
            end
         end
         if (poke && k == 7) begin
            bus.start  = 1'b1;
            bus.key_in = {$urandom, $urandom};
            @(posedge clk); #1;
            bus.start = 1'b0;
            check("start_in_run_round", 64'(bus.round), 64'(7));
            check("start_in_run_valid", 64'(bus.key_valid), 64'(1));
         end
         g = gaps ? int'($urandom_range(0, 2)) : 0;
         repeat (g) begin
            @(posedge clk); #1;
         end
         bus.advance = 1'b1;
         if (k == 15) done_exp++;
         @(posedge clk); #1;
         bus.advance = 1'b0;
      end
      check("done_pulse", 64'(bus.done), 64'(1));
      check("key_valid_fall", 64'(bus.key_valid), 64'(0));
   endtask

   initial begin
      bus.start   = 1'b0;
      bus.decrypt = 1'b0;
      bus.key_in  = '0;
      bus.advance = 1'b0;
      rst_n       = 1'b0;
      #12;
      check("reset_key_valid", 64'(bus.key_valid), 64'(0));
      check("reset_r_key", 64'(bus.r_key), 64'(0));
      check("reset_round", 64'(bus.round), 64'(0));
      check("reset_done", 64'(bus.done), 64'(0));
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Encrypt with a stall at round 3 and an ignored start at round 7.
      run(KnownKey, KnownKey, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0);
      // Decrypt back-to-back, advance held high throughout.
      run(KnownKey, KnownKey, 1'b1, 1'b1, 1'b0, -1, 1'b0, 1'b0);

      // Advance while idle does nothing.
      @(posedge clk); #1;
      bus.advance = 1'b1;
      @(posedge clk); #1;
      bus.advance = 1'b0;
      check("idle_adv_valid", 64'(bus.key_valid), 64'(0));
      check("idle_adv_round", 64'(bus.round), 64'(0));
      check("idle_adv_done", 64'(bus.done), 64'(0));

      // Start and advance together in idle.
      run(KnownKey, KnownKey, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b1);

      // Asynchronous reset mid-schedule at round 9.
      issue_start(KnownKey, KnownKey, 1'b0, 1'b0);
      bus.advance = 1'b1;
      repeat (9) begin
         @(posedge clk); #1;
      end
      bus.advance = 1'b0;
      check("pre_reset_round", 64'(bus.round), 64'(9));
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(bus.key_valid), 64'(0));
      check("async_rst_r_key", 64'(bus.r_key), 64'(0));
      check("async_rst_round", 64'(bus.round), 64'(0));
      check("async_rst_done", 64'(bus.done), 64'(0));
      exp_q.delete();
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      run(KnownKey, KnownKey, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0);

      // Parity bits ignored: flipped key must reproduce the unflipped schedule.
      run(ParKey ^ 64'h0101_0101_0101_0101, ParKey, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1);
      run(ParKey, ParKey, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0);

      // Random keys, direction and advance gaps.
      repeat (6) begin
         logic [63:0] rk;
         bit          rd;
         rk = {$urandom, $urandom};
         rd = 1'($urandom_range(0, 1));
         run(rk, rk, rd, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 20)), 1'b0,
             1'b1);
      end

      @(posedge clk); #1;
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      check("done_balance", 64'(done_exp), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
